// File: rtl/time_conf_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : time_conf_ctrl_if
// Purpose  : Button, time and configuration-output bundle of time_conf_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface time_conf_ctrl_if;
  logic        btn_mode;
  logic        btn_next;
  logic        btn_inc;
  logic [23:0] clock_time;
  logic [23:0] alarm_time;
  logic [1:0]  conf_stat;
  logic [23:0] conf_time;
  logic        conf_pulse;
  logic [1:0]  field_sel;
  logic [23:0] set_time;
  logic        load_clock;
  logic        load_alarm;

  modport master (
    output btn_mode, btn_next, btn_inc, clock_time, alarm_time,
    input  conf_stat, conf_time, conf_pulse, field_sel, set_time, load_clock, load_alarm
  );

  modport slave (
    input  btn_mode, btn_next, btn_inc, clock_time, alarm_time,
    output conf_stat, conf_time, conf_pulse, field_sel, set_time, load_clock, load_alarm
  );
endinterface
`default_nettype wire

// File: rtl/time_conf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : time_conf_ctrl
// Purpose  : Set-time / set-alarm editing FSM over a BCD hh:mm:ss buffer.
//            Optional edit-abandon timeout enabled by macro CONF_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module time_conf_ctrl #(
  parameter int TIMEOUT_CYCLES = 30
) (
  input  logic             clk,
  input  logic             rst,
  time_conf_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SET_TIME  = 2'd1,
    ST_SET_ALARM = 2'd2
  } state_t;

  localparam logic [7:0] c_hour_lim = 8'h23;
  localparam logic [7:0] c_min_lim  = 8'h59;

  state_t      r_state;
  logic [23:0] r_conf_time;
  logic [23:0] r_set_time;
  logic [1:0]  r_field_sel;
  logic        r_conf_upd;
  logic        r_conf_pulse;
  logic        r_load_clock;
  logic        r_load_alarm;

  logic [23:0] w_inc_time;
  logic        w_any_btn;
  logic        w_timeout;

  // Invalid BCD or at/above the field limit wraps to 00.
  function automatic logic [7:0] bcd_inc(input logic [7:0] f, input logic [7:0] lim);
    if ((f[7:4] > 4'd9) || (f[3:0] > 4'd9) || (f >= lim))
      return 8'h00;
    else if (f[3:0] == 4'd9)
      return {f[7:4] + 4'd1, 4'd0};
    else
      return {f[7:4], f[3:0] + 4'd1};
  endfunction

  always_comb begin
    w_inc_time = r_conf_time;
    case (r_field_sel)
      2'd0:    w_inc_time[23:16] = bcd_inc(r_conf_time[23:16], c_hour_lim);
      2'd1:    w_inc_time[15:8]  = bcd_inc(r_conf_time[15:8],  c_min_lim);
      default: w_inc_time[7:0]   = bcd_inc(r_conf_time[7:0],   c_min_lim);
    endcase
  end

  assign w_any_btn = bus.btn_mode | bus.btn_next | bus.btn_inc;

`ifdef CONF_TIMEOUT_EN
  localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);

  logic [c_cnt_w-1:0] r_idle_cnt;

  // Fires on the edge at which the idle count would reach TIMEOUT_CYCLES.
  assign w_timeout = (r_state != ST_IDLE) && !w_any_btn &&
                     (r_idle_cnt == c_cnt_w'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_idle_cnt <= '0;
    else if ((r_state == ST_IDLE) || w_any_btn || w_timeout)
      r_idle_cnt <= '0;
    else
      r_idle_cnt <= r_idle_cnt + 1'b1;
  end
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_conf_time  <= '0;
      r_set_time   <= '0;
      r_field_sel  <= '0;
      r_conf_upd   <= 1'b0;
      r_conf_pulse <= 1'b0;
      r_load_clock <= 1'b0;
      r_load_alarm <= 1'b0;
    end else begin
      r_load_clock <= 1'b0;
      r_load_alarm <= 1'b0;
      r_conf_upd   <= 1'b0;
      // Screen strobe trails the buffer change by one cycle.
      r_conf_pulse <= r_conf_upd;
      case (r_state)
        ST_IDLE: begin
          if (bus.btn_mode) begin
            r_state     <= ST_SET_TIME;
            r_conf_time <= bus.clock_time;
            r_field_sel <= 2'd0;
            r_conf_upd  <= 1'b1;
          end
        end
        ST_SET_TIME, ST_SET_ALARM: begin
          if (bus.btn_mode) begin
            r_set_time <= r_conf_time;
            if (r_state == ST_SET_TIME) begin
              r_load_clock <= 1'b1;
              r_state      <= ST_SET_ALARM;
              r_conf_time  <= bus.alarm_time;
              r_field_sel  <= 2'd0;
              r_conf_upd   <= 1'b1;
            end else begin
              r_load_alarm <= 1'b1;
              r_state      <= ST_IDLE;
            end
          end else if (bus.btn_next) begin
            r_field_sel <= (r_field_sel == 2'd2) ? 2'd0 : r_field_sel + 2'd1;
          end else if (bus.btn_inc) begin
            r_conf_time <= w_inc_time;
            r_conf_upd  <= 1'b1;
          end else if (w_timeout) begin
            r_state     <= ST_IDLE;
            r_field_sel <= 2'd0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.conf_stat  = r_state;
  assign bus.conf_time  = r_conf_time;
  assign bus.conf_pulse = r_conf_pulse;
  assign bus.field_sel  = r_field_sel;
  assign bus.set_time   = r_set_time;
  assign bus.load_clock = r_load_clock;
  assign bus.load_alarm = r_load_alarm;

endmodule
`default_nettype wire

// File: tb/tb_time_conf_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_conf_ctrl
// Purpose  : Self-checking bench for time_conf_ctrl (scoreboard queues).
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_conf_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_load_clock = 0;
  int   n_load_alarm = 0;
  logic [23:0] sb_conf[$];
  logic [23:0] sb_commit[$];

  time_conf_ctrl_if bus();

  time_conf_ctrl #(.TIMEOUT_CYCLES(30)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.load_clock) n_load_clock <= n_load_clock + 1;
    if (bus.load_alarm) n_load_alarm <= n_load_alarm + 1;
  end

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic press(input bit m, input bit n, input bit i);
    @(negedge clk);
    bus.btn_mode = m;
    bus.btn_next = n;
    bus.btn_inc  = i;
    @(posedge clk);
    #1;
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_inc  = 1'b0;
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    sb_conf.delete();
    sb_commit.delete();
  endtask

  task automatic test_reset;
    logic [54:0] obs;
    rst = 1'b1;
    bus.btn_mode = 1'b0;
    bus.btn_next = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.clock_time = 24'h0;
    bus.alarm_time = 24'h0;
    repeat (2) next_cycle();
    obs = {bus.conf_stat, bus.conf_time, bus.conf_pulse, bus.field_sel,
           bus.set_time, bus.load_clock, bus.load_alarm};
    n_checks++;
    if (obs !== 55'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_idle: conf_stat got %0d want 0", bus.conf_stat);
    end
  endtask

  task automatic test_enter;
    logic [23:0] exp;
    do_reset();
    bus.clock_time = 24'h123456;
    sb_conf.push_back(24'h123456);
    press(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bus.conf_stat !== 2'd1 || bus.field_sel !== 2'd0 || bus.conf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_state: stat %0d field %0d pulse %b want 1 0 0",
               bus.conf_stat, bus.field_sel, bus.conf_pulse);
    end
    next_cycle();
    n_checks++;
    if (bus.conf_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL enter_pulse: got %b want 1", bus.conf_pulse);
    end
    exp = sb_conf.pop_front();
    n_checks++;
    if (bus.conf_time !== exp) begin
      n_fail++;
      $display("FAIL enter_conf_time: got %h want %h", bus.conf_time, exp);
    end
    next_cycle();
    n_checks++;
    if (bus.conf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL enter_pulse_width: got %b want 0", bus.conf_pulse);
    end
  endtask

  task automatic test_inc_wrap;
    bit [4:0]    ops;
    logic [23:0] ev [0:4];
    logic [23:0] exp;
    logic [1:0]  fsel;
    ops = 5'b00010;
    ev  = '{24'h005837, 24'h005837, 24'h005937, 24'h000037, 24'h000137};
    fsel = 2'd0;
    do_reset();
    bus.clock_time = 24'h235837;
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int s = 0; s < 5; s++) begin
      if (ops[s]) begin
        press(1'b0, 1'b1, 1'b0);
        fsel = (fsel == 2'd2) ? 2'd0 : fsel + 2'd1;
        n_checks++;
        if (bus.field_sel !== fsel) begin
          n_fail++;
          $display("FAIL wrap_field: got %0d want %0d", bus.field_sel, fsel);
        end
      end else begin
        sb_conf.push_back(ev[s]);
        press(1'b0, 1'b0, 1'b1);
        next_cycle();
        exp = sb_conf.pop_front();
        n_checks++;
        if (bus.conf_pulse !== 1'b1 || bus.conf_time !== exp) begin
          n_fail++;
          $display("FAIL wrap_inc step %0d: time %h pulse %b want %h 1",
                   s, bus.conf_time, bus.conf_pulse, exp);
        end
      end
    end
  endtask

  task automatic test_bcd_edges;
    bit [6:0]    ops;
    logic [23:0] ev [0:6];
    logic [23:0] exp;
    logic [1:0]  fsel;
    ops = 7'b0101010;
    ev  = '{24'h00095F, 24'h0, 24'h00105F, 24'h0, 24'h001000, 24'h0, 24'h011000};
    fsel = 2'd0;
    do_reset();
    bus.clock_time = 24'h1A095F;
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    for (int s = 0; s < 7; s++) begin
      if (ops[s]) begin
        press(1'b0, 1'b1, 1'b0);
        fsel = (fsel == 2'd2) ? 2'd0 : fsel + 2'd1;
        n_checks++;
        if (bus.field_sel !== fsel) begin
          n_fail++;
          $display("FAIL bcd_field: got %0d want %0d", bus.field_sel, fsel);
        end
      end else begin
        sb_conf.push_back(ev[s]);
        press(1'b0, 1'b0, 1'b1);
        next_cycle();
        exp = sb_conf.pop_front();
        n_checks++;
        if (bus.conf_pulse !== 1'b1 || bus.conf_time !== exp) begin
          n_fail++;
          $display("FAIL bcd_inc step %0d: time %h pulse %b want %h 1",
                   s, bus.conf_time, bus.conf_pulse, exp);
        end
      end
    end
  endtask

  task automatic test_commit;
    logic [23:0] exp;
    do_reset();
    bus.clock_time = 24'h091500;
    bus.alarm_time = 24'h063000;
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    press(1'b0, 1'b1, 1'b0);
    sb_commit.push_back(24'h091500);
    sb_conf.push_back(24'h063000);
    press(1'b1, 1'b0, 1'b0);
    exp = sb_commit.pop_front();
    n_checks++;
    if (bus.load_clock !== 1'b1 || bus.load_alarm !== 1'b0 || bus.set_time !== exp) begin
      n_fail++;
      $display("FAIL commit_clock: load_clock %b load_alarm %b set_time %h want 1 0 %h",
               bus.load_clock, bus.load_alarm, bus.set_time, exp);
    end
    n_checks++;
    if (bus.conf_stat !== 2'd2 || bus.field_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL commit_to_alarm: stat %0d field %0d want 2 0", bus.conf_stat, bus.field_sel);
    end
    next_cycle();
    exp = sb_conf.pop_front();
    n_checks++;
    if (bus.load_clock !== 1'b0 || bus.conf_pulse !== 1'b1 || bus.conf_time !== exp) begin
      n_fail++;
      $display("FAIL commit_alarm_load: load_clock %b pulse %b time %h want 0 1 %h",
               bus.load_clock, bus.conf_pulse, bus.conf_time, exp);
    end
    sb_commit.push_back(24'h063000);
    press(1'b1, 1'b0, 1'b0);
    exp = sb_commit.pop_front();
    n_checks++;
    if (bus.load_alarm !== 1'b1 || bus.set_time !== exp || bus.conf_stat !== 2'd0 ||
        bus.conf_time !== 24'h063000) begin
      n_fail++;
      $display("FAIL commit_alarm: load_alarm %b set_time %h stat %0d time %h want 1 %h 0 063000",
               bus.load_alarm, bus.set_time, bus.conf_stat, bus.conf_time, exp);
    end
    next_cycle();
    n_checks++;
    if (bus.load_alarm !== 1'b0 || bus.set_time !== 24'h063000 || bus.conf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL commit_hold: load_alarm %b set_time %h pulse %b want 0 063000 0",
               bus.load_alarm, bus.set_time, bus.conf_pulse);
    end
  endtask

  task automatic test_priority;
    logic [23:0] exp;
    do_reset();
    bus.clock_time = 24'h101010;
    bus.alarm_time = 24'h221100;
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    sb_commit.push_back(24'h101010);
    press(1'b1, 1'b0, 1'b1);
    exp = sb_commit.pop_front();
    n_checks++;
    if (bus.load_clock !== 1'b1 || bus.set_time !== exp || bus.conf_stat !== 2'd2 ||
        bus.conf_time !== 24'h221100) begin
      n_fail++;
      $display("FAIL prio_mode_inc: load_clock %b set_time %h stat %0d time %h want 1 %h 2 221100",
               bus.load_clock, bus.set_time, bus.conf_stat, bus.conf_time, exp);
    end
    next_cycle();
    press(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bus.field_sel !== 2'd1 || bus.conf_time !== 24'h221100) begin
      n_fail++;
      $display("FAIL prio_next_inc: field %0d time %h want 1 221100", bus.field_sel, bus.conf_time);
    end
    next_cycle();
    n_checks++;
    if (bus.conf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL prio_no_pulse: got %b want 0", bus.conf_pulse);
    end
  endtask

  task automatic test_back_to_back;
    logic [23:0] exp;
    do_reset();
    bus.clock_time = 24'h084509;
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    press(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sb_conf.push_back({8'h08, 8'h46 + 8'(i), 8'h09});
      press(1'b0, 1'b0, 1'b1);
      exp = sb_conf.pop_front();
      n_checks++;
      if (bus.conf_time !== exp || bus.conf_pulse !== (i > 0)) begin
        n_fail++;
        $display("FAIL b2b_inc %0d: time %h pulse %b want %h %b",
                 i, bus.conf_time, bus.conf_pulse, exp, (i > 0));
      end
    end
    next_cycle();
    n_checks++;
    if (bus.conf_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_last_pulse: got %b want 1", bus.conf_pulse);
    end
    next_cycle();
    n_checks++;
    if (bus.conf_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_pulse_end: got %b want 0", bus.conf_pulse);
    end
  endtask

  task automatic test_timeout;
    int lc0;
    int la0;
    do_reset();
    bus.clock_time = 24'h010203;
    lc0 = n_load_clock;
    la0 = n_load_alarm;
    press(1'b1, 1'b0, 1'b0);
`ifdef CONF_TIMEOUT_EN
    press(1'b0, 1'b1, 1'b0);
    repeat (29) next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_early: stat %0d want 1", bus.conf_stat);
    end
    next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd0 || bus.field_sel !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_abort: stat %0d field %0d want 0 0", bus.conf_stat, bus.field_sel);
    end
    press(1'b1, 1'b0, 1'b0);
    repeat (19) next_cycle();
    press(1'b0, 1'b1, 1'b0);
    repeat (25) next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd1) begin
      n_fail++;
      $display("FAIL timeout_restart: stat %0d want 1 at cycle 45", bus.conf_stat);
    end
    repeat (5) next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd0) begin
      n_fail++;
      $display("FAIL timeout_second: stat %0d want 0", bus.conf_stat);
    end
`else
    repeat (45) next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd1) begin
      n_fail++;
      $display("FAIL no_timeout_persist: stat %0d want 1", bus.conf_stat);
    end
`endif
    next_cycle();
    n_checks++;
    if (n_load_clock !== lc0 || n_load_alarm !== la0) begin
      n_fail++;
      $display("FAIL timeout_no_load: clock loads %0d alarm loads %0d want %0d %0d",
               n_load_clock, n_load_alarm, lc0, la0);
    end
  endtask

  task automatic test_rst_mid_edit;
    logic [54:0] obs;
    int la0;
    do_reset();
    bus.clock_time = 24'h111111;
    bus.alarm_time = 24'h121212;
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    next_cycle();
    la0 = n_load_alarm;
    press(1'b0, 1'b0, 1'b1);
    bus.btn_inc  = 1'b1;
    bus.btn_mode = 1'b1;
    rst = 1'b1;
    #1;
    obs = {bus.conf_stat, bus.conf_time, bus.conf_pulse, bus.field_sel,
           bus.set_time, bus.load_clock, bus.load_alarm};
    n_checks++;
    if (obs !== 55'h0) begin
      n_fail++;
      $display("FAIL rst_async: got %h want 0", obs);
    end
    @(negedge clk);
    rst = 1'b0;
    bus.btn_inc  = 1'b0;
    bus.btn_mode = 1'b0;
    repeat (3) next_cycle();
    n_checks++;
    if (bus.conf_stat !== 2'd0 || bus.conf_pulse !== 1'b0 || n_load_alarm !== la0) begin
      n_fail++;
      $display("FAIL rst_no_commit: stat %0d pulse %b alarm loads %0d want 0 0 %0d",
               bus.conf_stat, bus.conf_pulse, n_load_alarm, la0);
    end
  endtask

  initial begin
    test_reset();
    test_enter();
    test_inc_wrap();
    test_bcd_edges();
    test_commit();
    test_priority();
    test_back_to_back();
    test_timeout();
    test_rst_mid_edit();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
